// File: rtl/mem_block_mover_pkg.sv
// Shared definitions for the block mover: default widths, FSM states and transfer modes.
package mem_block_mover_pkg;

    localparam int MB_ADDR_W = 10;
    localparam int MB_DATA_W = 32;
    localparam int MB_LEN_W  = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover.sv
// Memory-port initiator that copies a block of words or fills a block with a constant.
// Owns the single data-memory port while busy; words are processed in ascending address order.
module mem_block_mover
    import mem_block_mover_pkg::*;
#(
    parameter int ADDR_W = MB_ADDR_W,
    parameter int DATA_W = MB_DATA_W,
    parameter int LEN_W  = MB_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fillValue,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWE,
    output logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] memDataOut
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
    logic [DATA_W-1:0] lastData_q, lastData_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_COPY;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            fill_q     <= '0;
            hold_q     <= '0;
            lastAddr_q <= '0;
            lastData_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            fill_q     <= fill_d;
            hold_q     <= hold_d;
            lastAddr_q <= lastAddr_d;
            lastData_q <= lastData_d;
        end
    end

    // The port outputs are combinational from state so a reset drops memWE immediately;
    // outside READ/WRITE the address and write data replay their last driven values.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        fill_d    = fill_q;
        hold_d    = hold_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        memWE     = 1'b0;
        memAddr   = lastAddr_q;
        memDataIn = lastData_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = srcAddr;
                    dst_d  = dstAddr;
                    rem_d  = len;
                    fill_d = fillValue;
                    if (len == LEN_ZERO)
                        state_d = FINISH;
                    else if (mode == MODE_FILL)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                memAddr = src_q;
                hold_d  = memDataOut;
                state_d = WRITE;
            end
            WRITE: begin
                memAddr   = dst_q;
                memWE     = 1'b1;
                memDataIn = (mode_q == MODE_FILL) ? fill_q : hold_q;
                src_d     = src_q + ADDR_ONE;
                dst_d     = dst_q + ADDR_ONE;
                rem_d     = rem_q - LEN_ONE;
                if (rem_q == LEN_ONE)
                    state_d = FINISH;
                else if (mode_q == MODE_FILL)
                    state_d = WRITE;
                else
                    state_d = READ;
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        lastAddr_d = memAddr;
        lastData_d = memDataIn;
    end

endmodule
